// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready requesters,
// gates FIFO pops with a consumer ready, tracks occupancy and runs a flush/drain sequence.
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_BITS = 3,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_empty_i,
  output logic                          fifo_pop_o,
  output logic                          cons_valid_o,
  input  logic                          cons_ready_i,
  input  logic                          flush_i,
  output logic                          flush_done_o,
  output logic [IDX_W-1:0]              grant_idx_o,
  output logic [DEPTH_BITS:0]           count_o
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    rr_ptr_reg;
  logic [DEPTH_BITS:0] count_reg;
  logic                flush_done_reg;

  logic [DATA_WIDTH-1:0] payload [NUM_REQ];
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand_idx;
  logic                  any_valid;
  logic                  push_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign payload[gi]     = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready_o[gi] = push_ok && any_valid && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // Walk from the slot after the last grant, wrapping at NUM_REQ-1 so non-power-of-two counts work.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    cand_idx  = rr_ptr_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = (cand_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cand_idx + 1'b1;
      if (!any_valid && req_valid_i[cand_idx]) begin
        grant_idx = cand_idx;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_pop_o   = 1'b0;
    cons_valid_o = 1'b0;
    case (state_reg)
      RUN: begin
        fifo_pop_o   = !fifo_empty_i && cons_ready_i;
        cons_valid_o = !fifo_empty_i;
      end
      DRAIN:   fifo_pop_o = !fifo_empty_i;
      default: ;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok      = (state_reg == RUN) && (!fifo_full_i || fifo_pop_o);
  assign fifo_push_o  = push_ok && any_valid;
  assign fifo_data_o  = any_valid ? payload[grant_idx] : '0;
  assign grant_idx_o  = grant_idx;
  assign count_o      = count_reg;
  assign flush_done_o = flush_done_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= RUN;
      rr_ptr_reg     <= IDX_W'(NUM_REQ - 1);
      count_reg      <= '0;
      flush_done_reg <= 1'b0;
    end else begin
      if (fifo_push_o) begin
        rr_ptr_reg <= grant_idx;
      end
      count_reg <= count_reg + {{DEPTH_BITS{1'b0}}, fifo_push_o}
                             - {{DEPTH_BITS{1'b0}}, fifo_pop_o};
      flush_done_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (flush_i) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty_i) begin
            state_reg      <= DONE;
            flush_done_reg <= 1'b1;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Testbench for fifo_push_arbiter: a behavioural 8-entry FIFO sits beside the DUT, and
// expected grants and consumer data are queued up front and compared as the DUT acts.
module tb_fifo_push_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int DB = 3;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready_o;
  logic            fifo_push_o;
  logic [DW-1:0]   fifo_data_o;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop_o;
  logic            cons_valid_o;
  logic            cons_ready = 1'b0;
  logic            flush = 1'b0;
  logic            flush_done_o;
  logic [1:0]      grant_idx_o;
  logic [DB:0]     count_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_grant [$];
  logic [7:0] exp_cons  [$];

  always #5 clk = ~clk;

  fifo_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH_BITS(DB)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready_o),
    .fifo_push_o  (fifo_push_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_full_i  (fifo_full),
    .fifo_empty_i (fifo_empty),
    .fifo_pop_o   (fifo_pop_o),
    .cons_valid_o (cons_valid_o),
    .cons_ready_i (cons_ready),
    .flush_i      (flush),
    .flush_done_o (flush_done_o),
    .grant_idx_o  (grant_idx_o),
    .count_o      (count_o)
  );

  // Shared FIFO beside the arbiter, reset by the same resetn.
  logic [7:0] fm_mem [8];
  logic [2:0] fm_rd, fm_wr;
  logic [3:0] fm_cnt;
  logic [7:0] fm_head;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fm_rd  <= '0;
      fm_wr  <= '0;
      fm_cnt <= '0;
    end else begin
      if (fifo_pop_o) fm_rd <= fm_rd + 3'd1;
      if (fifo_push_o) begin
        fm_mem[fm_wr] <= fifo_data_o;
        fm_wr         <= fm_wr + 3'd1;
      end
      fm_cnt <= fm_cnt + {3'b0, fifo_push_o} - {3'b0, fifo_pop_o};
    end
  end
  assign fifo_full  = (fm_cnt == 4'd8);
  assign fifo_empty = (fm_cnt == 4'd0);
  assign fm_head    = fm_mem[fm_rd];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (count_o !== 4'd0 || flush_done_o !== 1'b0)
      $display("FAIL reset_regs: count=%0d done=%b, expected 0/0", count_o, flush_done_o);
    else n_pass++;
    n_checks++;
    if ({req_ready_o, fifo_push_o, fifo_pop_o, cons_valid_o, fifo_data_o, grant_idx_o} !== '0)
      $display("FAIL reset_comb: ready=%b push=%b pop=%b cv=%b data=%h grant=%0d, expected all 0",
               req_ready_o, fifo_push_o, fifo_pop_o, cons_valid_o, fifo_data_o, grant_idx_o);
    else n_pass++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_drain();
    logic [7:0] ev;
    req_valid  = '0;
    cons_ready = 1'b1;
    for (int k = 0; k < 12 && fifo_empty !== 1'b1; k++) begin
      @(negedge clk);
      if (fifo_pop_o === 1'b1) begin
        n_checks++;
        if (exp_cons.size() == 0) $display("FAIL drain_cons: unexpected pop head=%h", fm_head);
        else begin
          ev = exp_cons.pop_front();
          if (fm_head !== ev) $display("FAIL drain_cons: got %h expected %h", fm_head, ev);
          else n_pass++;
        end
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (count_o !== 4'd0 || fifo_empty !== 1'b1 || exp_cons.size() != 0)
      $display("FAIL drain_end: count=%0d empty=%b left=%0d, expected 0/1/0",
               count_o, fifo_empty, exp_cons.size());
    else n_pass++;
    tick();
  endtask

  task automatic test_fairness();
    int rdy_cnt [NR];
    logic [1:0] eg;
    logic [7:0] ev;
    foreach (rdy_cnt[i]) rdy_cnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      exp_grant.push_back(2'(k % 4));
      exp_cons.push_back(8'h40 + 8'(k % 4));
    end
    req_data   = 32'h43424140;
    req_valid  = 4'hF;
    cons_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) if (req_ready_o[i]) rdy_cnt[i]++;
      eg = exp_grant.pop_front();
      n_checks++;
      if (fifo_push_o !== 1'b1 || grant_idx_o !== eg || fifo_data_o !== 8'h40 + 8'(eg)
          || req_ready_o !== (4'b0001 << eg))
        $display("FAIL fair_grant cyc %0d: push=%b grant=%0d data=%h ready=%b, expected grant %0d",
                 k, fifo_push_o, grant_idx_o, fifo_data_o, req_ready_o, eg);
      else n_pass++;
      if (fifo_pop_o === 1'b1) begin
        n_checks++;
        if (exp_cons.size() == 0) $display("FAIL fair_cons: unexpected pop head=%h", fm_head);
        else begin
          ev = exp_cons.pop_front();
          if (fm_head !== ev) $display("FAIL fair_cons: got %h expected %h", fm_head, ev);
          else n_pass++;
        end
      end
      tick();
    end
    req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      n_checks++;
      if (rdy_cnt[i] != 2) $display("FAIL fair_count req %0d: got %0d readys expected 2", i, rdy_cnt[i]);
      else n_pass++;
    end
    test_drain();
  endtask

  task automatic test_fill();
    cons_ready = 1'b0;
    req_valid  = 4'b0100;
    for (int k = 0; k < 8; k++) exp_cons.push_back(8'h10 + 8'(k));
    for (int k = 0; k < 8; k++) begin
      req_data[23:16] = 8'h10 + 8'(k);
      @(negedge clk);
      n_checks++;
      if (fifo_push_o !== 1'b1 || grant_idx_o !== 2'd2 || fifo_data_o !== 8'h10 + 8'(k)
          || req_ready_o !== 4'b0100)
        $display("FAIL fill_push %0d: push=%b grant=%0d data=%h ready=%b, expected 1/2/%h/0100",
                 k, fifo_push_o, grant_idx_o, fifo_data_o, req_ready_o, 8'h10 + 8'(k));
      else n_pass++;
      tick();
    end
    req_data[23:16] = 8'h18;
    @(negedge clk);
    n_checks++;
    if (count_o !== 4'd8 || fifo_full !== 1'b1 || req_ready_o !== 4'b0 || fifo_push_o !== 1'b0)
      $display("FAIL fill_full: count=%0d full=%b ready=%b push=%b, expected 8/1/0000/0",
               count_o, fifo_full, req_ready_o, fifo_push_o);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (count_o !== 4'd8 || fifo_pop_o !== 1'b0 || cons_valid_o !== 1'b1)
      $display("FAIL fill_hold: count=%0d pop=%b cv=%b, expected 8/0/1", count_o, fifo_pop_o, cons_valid_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_full_pop();
    logic [7:0] ev;
    req_valid       = 4'b0010;
    req_data[15:8]  = 8'hAA;
    cons_ready      = 1'b1;
    exp_cons.push_back(8'hAA);
    @(negedge clk);
    n_checks++;
    if (fifo_push_o !== 1'b1 || fifo_pop_o !== 1'b1 || grant_idx_o !== 2'd1
        || fifo_data_o !== 8'hAA || req_ready_o !== 4'b0010)
      $display("FAIL full_pop_strobe: push=%b pop=%b grant=%0d data=%h ready=%b, expected 1/1/1/aa/0010",
               fifo_push_o, fifo_pop_o, grant_idx_o, fifo_data_o, req_ready_o);
    else n_pass++;
    if (fifo_pop_o === 1'b1) begin
      n_checks++;
      if (exp_cons.size() == 0) $display("FAIL full_pop_cons: unexpected pop head=%h", fm_head);
      else begin
        ev = exp_cons.pop_front();
        if (fm_head !== ev) $display("FAIL full_pop_cons: got %h expected %h", fm_head, ev);
        else n_pass++;
      end
    end
    tick();
    req_valid  = '0;
    cons_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count_o !== 4'd8) $display("FAIL full_pop_count: got %0d expected 8", count_o);
    else n_pass++;
    tick();
    test_drain();
  endtask

  task automatic test_skip();
    logic [1:0] eg;
    logic [7:0] ev;
    for (int k = 0; k < 4; k++) begin
      exp_grant.push_back((k % 2 == 0) ? 2'd3 : 2'd1);
      exp_cons.push_back((k % 2 == 0) ? 8'h53 : 8'h51);
    end
    req_data   = 32'h53525150;
    req_valid  = 4'b1010;
    cons_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      eg = exp_grant.pop_front();
      n_checks++;
      if (fifo_push_o !== 1'b1 || grant_idx_o !== eg || req_ready_o !== (4'b0001 << eg))
        $display("FAIL skip_grant cyc %0d: push=%b grant=%0d ready=%b, expected grant %0d",
                 k, fifo_push_o, grant_idx_o, req_ready_o, eg);
      else n_pass++;
      if (fifo_pop_o === 1'b1) begin
        n_checks++;
        if (exp_cons.size() == 0) $display("FAIL skip_cons: unexpected pop head=%h", fm_head);
        else begin
          ev = exp_cons.pop_front();
          if (fm_head !== ev) $display("FAIL skip_cons: got %h expected %h", fm_head, ev);
          else n_pass++;
        end
      end
      tick();
    end
    test_drain();
  endtask

  task automatic test_flush();
    cons_ready = 1'b0;
    req_valid  = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      req_data[7:0] = 8'h60 + 8'(k);
      @(negedge clk);
      n_checks++;
      if (fifo_push_o !== 1'b1 || grant_idx_o !== 2'd0 || fifo_data_o !== 8'h60 + 8'(k))
        $display("FAIL flush_fill %0d: push=%b grant=%0d data=%h, expected 1/0/%h",
                 k, fifo_push_o, grant_idx_o, fifo_data_o, 8'h60 + 8'(k));
      else n_pass++;
      tick();
    end
    req_valid = '0;
    flush     = 1'b1;
    @(negedge clk);
    n_checks++;
    if (count_o !== 4'd5 || fifo_push_o !== 1'b0)
      $display("FAIL flush_req: count=%0d push=%b, expected 5/0", count_o, fifo_push_o);
    else n_pass++;
    tick();
    flush     = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h73727170;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_pop_o !== 1'b1 || cons_valid_o !== 1'b0 || req_ready_o !== 4'b0
          || fifo_push_o !== 1'b0 || count_o !== 4'(5 - k))
        $display("FAIL flush_drain %0d: pop=%b cv=%b ready=%b push=%b count=%0d, expected 1/0/0000/0/%0d",
                 k, fifo_pop_o, cons_valid_o, req_ready_o, fifo_push_o, count_o, 5 - k);
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (fifo_pop_o !== 1'b0 || req_ready_o !== 4'b0 || flush_done_o !== 1'b0 || count_o !== 4'd0)
      $display("FAIL flush_drain_empty: pop=%b ready=%b done=%b count=%0d, expected 0/0000/0/0",
               fifo_pop_o, req_ready_o, flush_done_o, count_o);
    else n_pass++;
    tick();
    exp_cons.push_back(8'h71);
    @(negedge clk);
    n_checks++;
    if (flush_done_o !== 1'b1 || req_ready_o !== 4'b0 || fifo_push_o !== 1'b0)
      $display("FAIL flush_done: done=%b ready=%b push=%b, expected 1/0000/0",
               flush_done_o, req_ready_o, fifo_push_o);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (flush_done_o !== 1'b0 || count_o !== 4'd0 || fifo_push_o !== 1'b1
        || grant_idx_o !== 2'd1 || fifo_data_o !== 8'h71)
      $display("FAIL flush_resume: done=%b count=%0d push=%b grant=%0d data=%h, expected 0/0/1/1/71",
               flush_done_o, count_o, fifo_push_o, grant_idx_o, fifo_data_o);
    else n_pass++;
    tick();
    test_drain();
  endtask

  task automatic test_flush_empty();
    req_valid  = '0;
    cons_ready = 1'b0;
    flush      = 1'b1;
    tick();
    flush     = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (flush_done_o !== 1'b0 || fifo_pop_o !== 1'b0 || req_ready_o !== 4'b0)
      $display("FAIL fe_drain: done=%b pop=%b ready=%b, expected 0/0/0000", flush_done_o, fifo_pop_o, req_ready_o);
    else n_pass++;
    tick();
    exp_cons.push_back(8'h72);
    @(negedge clk);
    n_checks++;
    if (flush_done_o !== 1'b1 || req_ready_o !== 4'b0)
      $display("FAIL fe_done: done=%b ready=%b, expected 1/0000", flush_done_o, req_ready_o);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (flush_done_o !== 1'b0 || req_ready_o !== 4'b0100 || fifo_push_o !== 1'b1 || fifo_data_o !== 8'h72)
      $display("FAIL fe_run: done=%b ready=%b push=%b data=%h, expected 0/0100/1/72",
               flush_done_o, req_ready_o, fifo_push_o, fifo_data_o);
    else n_pass++;
    tick();
    test_drain();
  endtask

  task automatic test_async_reset();
    cons_ready = 1'b0;
    req_valid  = 4'b0001;
    req_data   = 32'h83828180;
    repeat (5) tick();
    req_valid = '0;
    flush     = 1'b1;
    @(negedge clk);
    n_checks++;
    if (count_o !== 4'd5) $display("FAIL ar_fill: count=%0d expected 5", count_o);
    else n_pass++;
    tick();
    flush      = 1'b0;
    req_valid  = 4'hF;
    cons_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if (count_o !== 4'd3 || req_ready_o !== 4'b0)
      $display("FAIL ar_mid_drain: count=%0d ready=%b, expected 3/0000", count_o, req_ready_o);
    else n_pass++;
    #2;
    resetn   = 1'b0;
    req_data = 32'h93929190;
    exp_cons.delete();
    exp_cons.push_back(8'h90);
    #1;
    n_checks++;
    if (count_o !== 4'd0 || flush_done_o !== 1'b0 || req_ready_o !== 4'b0001 || fifo_pop_o !== 1'b0)
      $display("FAIL ar_immediate: count=%0d done=%b ready=%b pop=%b, expected 0/0/0001/0",
               count_o, flush_done_o, req_ready_o, fifo_pop_o);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_checks++;
    if (fifo_push_o !== 1'b1 || grant_idx_o !== 2'd0 || fifo_data_o !== 8'h90)
      $display("FAIL ar_first_grant: push=%b grant=%0d data=%h, expected 1/0/90",
               fifo_push_o, grant_idx_o, fifo_data_o);
    else n_pass++;
    tick();
    test_drain();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_fill();
    test_full_pop();
    test_skip();
    test_flush();
    test_flush_empty();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded 50000 time units, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares one 2^DEPTH_BITS-entry FIFO write port among NUM_REQ requesters with round-robin arbitration.
- Each requester uses a valid/ready handshake. The block drives the FIFO push/pop strobes and gates pop with a consumer ready.
- Keeps a shadow occupancy count and provides a flush (drain) sequence.
- Sits between the IOMMU request sources and the shared FIFO, which is instantiated alongside it at the same level.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..8.
- DATA_WIDTH, 8, payload width per requester.
- DEPTH_BITS, 3, FIFO address width; capacity is 2^DEPTH_BITS entries.
- IDX_W (localparam), $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  out  NUM_REQ  per-requester ready; at most one bit high.
- fifo_push_o  out  1  FIFO push strobe.
- fifo_data_o  out  DATA_WIDTH  FIFO write data, i.e. the granted payload.
- fifo_full_i  in  1  FIFO full flag.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_pop_o  out  1  FIFO pop strobe.
- cons_valid_o  out  1  FIFO head valid toward the consumer.
- cons_ready_i  in  1  consumer accepts the head this cycle.
- flush_i  in  1  request to drain the FIFO.
- flush_done_o  out  1  one-cycle pulse when the drain completes.
- grant_idx_o  out  IDX_W  index of the current grant; valid when fifo_push_o=1.
- count_o  out  DEPTH_BITS+1  shadow occupancy.

Behaviour:
- Interface: reset resetn, asynchronous, active-low; clock clk. All state is on posedge clk; reset is asynchronous.

Reset values:
- state=RUN.
- rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- count_o=0.
- flush_done_o=0.
- All combinational outputs are 0 while fifo_empty_i=1 and no valid is asserted.

Push path (combinational):
- push_ok = (state==RUN) && (!fifo_full_i || fifo_pop_o).
- Grant goes to the first i with req_valid_i[i]=1, searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
- req_ready_o[grant] = push_ok. All other ready bits are 0.
- fifo_push_o = push_ok && any valid.
- fifo_data_o = payload of the granted requester.
- rr_ptr <= grant only on a cycle where fifo_push_o=1. rr_ptr is unchanged otherwise.

Requester rules:
- A requester holds valid and data stable until ready.
- Dropping valid early is legal and simply forfeits arbitration.

Pop path:
- In RUN: fifo_pop_o = !fifo_empty_i && cons_ready_i, and cons_valid_o = !fifo_empty_i.
- In DRAIN: fifo_pop_o = !fifo_empty_i, and cons_valid_o = 0 (entries are discarded).
- Pop is never asserted when fifo_empty_i=1.
- Push is never asserted when full unless pop is asserted in the same cycle.

Occupancy:
- count_o <= count_o + fifo_push_o - fifo_pop_o; push and pop together leave it unchanged.
- Invariants: count_o==0 iff fifo_empty_i; count_o==2^DEPTH_BITS iff fifo_full_i.
- count_o never exceeds 2^DEPTH_BITS and never underflows.

State machine:
- RUN: flush_i=1 -> DRAIN. A push in that same cycle still completes, because the transition takes effect next cycle.
- DRAIN:
  - No grants are issued.
  - Leaves for DONE when fifo_empty_i=1. If the FIFO is already empty on entry, DRAIN lasts one cycle.
  - flush_i is ignored while in DRAIN.
- DONE: flush_done_o=1 for exactly this cycle, no grants issued, unconditional transition -> RUN. flush_i sampled here is ignored.
- A flush_i that is still high on return to RUN starts a new flush.

Other rules:
- Reset mid-drain returns to RUN with count_o=0. The FIFO is reset by the same resetn.
- If NUM_REQ is not a power of two, the pointer wraps at NUM_REQ-1 -> 0.

Test Plan:
- Fairness: NUM_REQ=4, all valids held high for 8 cycles, cons_ready_i=1 -> grants go 0,1,2,3,0,1,2,3; each requester receives exactly 2 readys.
- Fill: cons_ready_i=0, req 2 pushes 0x10..0x17 -> count_o reaches 8 and fifo_full_i=1. A 9th valid gets ready=0 and count_o stays 8.
- Full with simultaneous pop: FIFO full, cons_ready_i=1, req 1 valid with 0xAA -> push and pop occur in the same cycle; count_o stays 8 and 0xAA becomes the last entry read.
- Skip idle requesters: only reqs 1 and 3 valid, rr_ptr=1 -> grant order 3,1,3,1; reqs 0 and 2 are never readied.
- Flush: 5 entries queued, flush_i pulsed -> next cycle is DRAIN with 5 pops and all readys 0, then DONE with flush_done_o=1 for one cycle, then RUN with count_o=0.
- Async reset: resetn asserted mid-DRAIN with count_o=3 -> immediately state=RUN, count_o=0, flush_done_o=0, and requester 0 is granted first after release.
